accum5_stage: RTL and testbench

- Sequential accumulation stage for the 5-bit ripple-carry add path.
- Accepts a stream of unsigned WIDTH-bit operands over a valid/ready handshake and adds each one into a running register through the ripple adder.
- After COUNT accepted operands it presents the sum, last carry and a sticky overflow flag downstream over a second valid/ready handshake, then restarts.
- Typical use: the register/control stage wrapped around the adder for multi-operand sums in lab datapaths.

---
 rtl/accum5_pkg.sv | 20 ++
 rtl/accum5_stage_if.sv | 23 ++
 rtl/accum5_add.sv | 20 ++
 rtl/accum5_stage.sv | 106 ++++++++++
 tb/tb_accum5_stage.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/accum5_pkg.sv
// Shared constants and state encoding for the accum5 accumulation stage.
package accum5_pkg;

    localparam int WIDTH_DEF = 5;
    localparam int COUNT_DEF = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // Operand counter width; never below one bit so COUNT=1 still has a register.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/accum5_stage_if.sv
// Operand-in and result-out handshake bundle for accum5_stage.
interface accum5_stage_if #(
    parameter int WIDTH = accum5_pkg::WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] acc;
    logic             carry_out;
    logic             ovf;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, acc, carry_out, ovf
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, acc, carry_out, ovf
    );
endinterface

// File: rtl/accum5_add.sv
// Combinational WIDTH-bit ripple-carry adder, carry-in tied low.
module accum5_add #(
    parameter int WIDTH = accum5_pkg::WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    logic [WIDTH:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign carry = c[WIDTH];
endmodule

// File: rtl/accum5_stage.sv
// Accumulates COUNT operands through the ripple adder and hands the sum downstream.
// Build option: define ACCUM5_SATURATE_EN to clamp acc to all-ones on carry.
//
// state | meaning
// ACCUM | taking operands, in_ready=1
// DONE  | result presented, out_valid=1, waiting for out_ready
module accum5_stage
    import accum5_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int COUNT = COUNT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    accum5_stage_if.slave  bus
);
    localparam int            CW       = clog2(COUNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(COUNT - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_carry;
    logic [WIDTH-1:0] acc_next;

    accum5_add #(.WIDTH(WIDTH)) u_add (
        .a     (acc_q),
        .b     (bus.in_data),
        .sum   (add_sum),
        .carry (add_carry)
    );

`ifdef ACCUM5_SATURATE_EN
    assign acc_next = add_carry ? {WIDTH{1'b1}} : add_sum;
`else
    assign acc_next = add_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        // clear wins over both a same-cycle accept and a same-cycle result handshake
        if (clear) begin
            state_d = ACCUM;
            cnt_d   = '0;
            acc_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_d   = acc_next;
                        carry_d = add_carry;
                        ovf_d   = ovf_q | add_carry;
                        if (cnt_q == CNT_LAST) begin
                            state_d = DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        carry_d = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == DONE);
    assign bus.acc       = acc_q;
    assign bus.carry_out = carry_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_accum5_stage.sv
// Directed self-checking bench for accum5_stage (COUNT=4 and COUNT=1 instances).
module tb_accum5_stage;
    logic clk;
    logic rst_n;
    logic clear;
    int   checks;
    int   errors;

    accum5_stage_if #(.WIDTH(5)) bus4 ();
    accum5_stage_if #(.WIDTH(5)) bus1 ();

    accum5_stage #(.WIDTH(5), .COUNT(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus4.slave)
    );

    accum5_stage #(.WIDTH(5), .COUNT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outputs are sampled and inputs changed 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed4(input int a, input int b, input int c, input int d);
        bus4.in_valid = 1'b1;
        bus4.in_data  = 5'(a); tick();
        bus4.in_data  = 5'(b); tick();
        bus4.in_data  = 5'(c); tick();
        bus4.in_data  = 5'(d); tick();
        bus4.in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear  = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
        #12 rst_n = 1'b1;
        tick();
        chk("rst_acc",       32'(bus4.acc), 0);
        chk("rst_out_valid", 32'(bus4.out_valid), 0);
        chk("rst_in_ready",  32'(bus4.in_ready), 1);

        // Reach DONE with ovf set, then reset asynchronously mid-cycle.
        feed4(31, 1, 0, 0);
        chk("pre_rst_done",  32'(bus4.out_valid), 1);
        chk("pre_rst_ovf",   32'(bus4.ovf), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_acc",       32'(bus4.acc), 0);
        chk("arst_carry",     32'(bus4.carry_out), 0);
        chk("arst_ovf",       32'(bus4.ovf), 0);
        chk("arst_out_valid", 32'(bus4.out_valid), 0);
        #1 rst_n = 1'b1;
        tick();
        chk("arst_in_ready",  32'(bus4.in_ready), 1);

        // Reset mid-batch must discard the operand count too.
        bus4.in_valid = 1'b1; bus4.in_data = 5'd1; tick(); tick();
        bus4.in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        chk("midrst_acc", 32'(bus4.acc), 0);

        // Basic batch: 3+5+7+9 = 24.
        bus4.out_ready = 1'b1;
        feed4(3, 5, 7, 9);
        chk("b1_out_valid", 32'(bus4.out_valid), 1);
        chk("b1_acc",       32'(bus4.acc), 24);
        chk("b1_carry",     32'(bus4.carry_out), 0);
        chk("b1_ovf",       32'(bus4.ovf), 0);
        chk("b1_in_ready",  32'(bus4.in_ready), 0);
        tick();
        chk("b1_post_acc",   32'(bus4.acc), 0);
        chk("b1_post_ready", 32'(bus4.in_ready), 1);
        chk("b1_post_valid", 32'(bus4.out_valid), 0);

        // Overflow batch 20,15,1,1 with backpressure afterwards.
        bus4.out_ready = 1'b0;
        feed4(20, 15, 1, 1);
`ifdef ACCUM5_SATURATE_EN
        chk("b2_acc_sat", 32'(bus4.acc), 31);
`else
        chk("b2_acc",     32'(bus4.acc), 5);
        chk("b2_carry",   32'(bus4.carry_out), 0);
`endif
        chk("b2_ovf",       32'(bus4.ovf), 1);
        chk("b2_out_valid", 32'(bus4.out_valid), 1);
        bus4.in_valid = 1'b1; bus4.in_data = 5'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready",  32'(bus4.in_ready), 0);
            chk("bp_out_valid", 32'(bus4.out_valid), 1);
`ifdef ACCUM5_SATURATE_EN
            chk("bp_acc", 32'(bus4.acc), 31);
`else
            chk("bp_acc", 32'(bus4.acc), 5);
`endif
            chk("bp_ovf", 32'(bus4.ovf), 1);
        end
        bus4.out_ready = 1'b1;
        tick();
        chk("bp_hs_acc",   32'(bus4.acc), 0);
        chk("bp_hs_ready", 32'(bus4.in_ready), 1);
        chk("bp_hs_ovf",   32'(bus4.ovf), 0);
        tick();
        chk("bp_pending_7", 32'(bus4.acc), 7);
        bus4.in_valid = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr1_acc", 32'(bus4.acc), 0);

        // Clear after two accepts, overriding a same-cycle accept.
        bus4.in_valid = 1'b1;
        bus4.in_data = 5'd3; tick();
        bus4.in_data = 5'd5; tick();
        chk("clr2_partial", 32'(bus4.acc), 8);
        bus4.in_data = 5'd9; clear = 1'b1; tick(); clear = 1'b0;
        bus4.in_valid = 1'b0;
        chk("clr2_acc",   32'(bus4.acc), 0);
        chk("clr2_ready", 32'(bus4.in_ready), 1);
        feed4(1, 1, 1, 1);
        chk("clr2_done_valid", 32'(bus4.out_valid), 1);
        chk("clr2_done_acc",   32'(bus4.acc), 4);

        // Clear together with the result handshake.
        clear = 1'b1; bus4.out_ready = 1'b1; tick(); clear = 1'b0;
        chk("clr3_out_valid", 32'(bus4.out_valid), 0);
        chk("clr3_in_ready",  32'(bus4.in_ready), 1);
        chk("clr3_acc",       32'(bus4.acc), 0);
        feed4(1, 2, 3, 4);
        chk("clr3_next_valid", 32'(bus4.out_valid), 1);
        chk("clr3_next_acc",   32'(bus4.acc), 10);
        tick();

        // COUNT=1: every accept completes a batch, result every 2 cycles.
        bus1.out_ready = 1'b1;
        bus1.in_valid = 1'b1; bus1.in_data = 5'd31;
        tick();
        chk("c1_a_valid", 32'(bus1.out_valid), 1);
        chk("c1_a_acc",   32'(bus1.acc), 31);
        chk("c1_a_carry", 32'(bus1.carry_out), 0);
        chk("c1_a_ovf",   32'(bus1.ovf), 0);
        chk("c1_a_ready", 32'(bus1.in_ready), 0);
        tick();
        chk("c1_hs_valid", 32'(bus1.out_valid), 0);
        chk("c1_hs_acc",   32'(bus1.acc), 0);
        tick();
        chk("c1_b_valid", 32'(bus1.out_valid), 1);
        chk("c1_b_acc",   32'(bus1.acc), 31);
        chk("c1_b_ovf",   32'(bus1.ovf), 0);
        bus1.in_valid = 1'b0;
        tick();
        chk("c1_end_valid", 32'(bus1.out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
